ex_lsq: RTL and testbench
=========================

Name: ex_lsq

Overview:
Parametrised in-order load/store execute unit. It replaces the single-slot load/store stage with a DEPTH-entry queue of address-resolved memory ops. It issues one request at a time to the data cache over a valid/ready handshake, then formats load results (byte lanes, sign/zero extension) for regfile writeback. Flush support and misalignment detection are new.

Parameters:
XLEN, 32, data/address width (32 only verified; byte-lane logic generic in XLEN/8)
DEPTH, 4, queue entries; power of two, >=2
TAG_W, 5, destination register address width
OP_W, 4, op code width; encoding {is_store, funct3}

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
rdy  in  1  global enable; when 0 all state holds and outputs hold
flush  in  1  discard all queued and in-flight ops
in_valid  in  1  op offered
in_ready  out  1  queue can accept (= !full)
in_op  in  OP_W  LB/LH/LW/LBU/LHU/SB/SH/SW
in_base  in  XLEN  rs1 value
in_offset  in  XLEN  sign-extended immediate
in_wdata  in  XLEN  rs2 value (stores)
in_target  in  TAG_W  rd (loads)
req_valid  out  1  cache request
req_ready  in  1  cache accepts
req_we  out  1  1=store
req_addr  out  XLEN  byte address
req_size  out  3  1/2/4 bytes
req_wdata  out  XLEN  store data, low bytes significant
resp_valid  in  1  load data return, one cycle pulse
resp_data  in  XLEN  byte at lowest address in [7:0]
wb_en  out  1  writeback strobe
wb_target  out  TAG_W  rd
wb_data  out  XLEN  formatted load result
misalign  out  1  one-cycle pulse, misaligned op dropped
busy  out  1  queue non-empty or FSM not IDLE

Behaviour:
- Reset: queue empty, pointers 0, FSM IDLE. in_ready=1 (DEPTH>=2). req_valid=0, req_we=0, req_addr=0, req_size=0, req_wdata=0, wb_en=0, wb_target=0, wb_data=0, misalign=0, busy=0. Reset mid-transaction abandons everything; a later resp_valid is ignored.
- Enqueue when in_valid&&in_ready&&rdy&&!flush. Store addr=in_base+in_offset (mod 2^XLEN), computed at enqueue. Full queue: in_ready=0, no same-cycle enqueue-on-dequeue bypass. Pointers wrap modulo DEPTH; full/empty use an extra pointer bit.
- FSM IDLE->REQ when queue non-empty.
  - Misalignment: in IDLE, if the head has half-word addr[0]!=0 or word addr[1:0]!=0, pulse misalign for 1 cycle. Pop the head with no request and no writeback, and stay IDLE.
  - REQ: req_valid=1 with head fields, all stable until accepted.
  - Store accepted (req_ready): pop and go to IDLE. Fire-and-forget, no writeback.
  - Load accepted: pop and go to WAIT, latching op/target/addr[1:0].
  - WAIT: on resp_valid, register the result; wb_en=1 the next cycle for exactly 1 cycle, then IDLE.
  - Minimum load latency: enqueue to req_valid is 2 cycles; resp_valid to wb_en is 1 cycle.
- Formatting: select byte/half by latched addr[1:0] from resp_data. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- rd==0 load: access is performed, wb_en suppressed.
- Undefined op code at head: dropped silently, no request, no misalign.
- flush (priority over all else, same cycle): queue emptied, req_valid=0 next cycle. In REQ -> IDLE. In WAIT -> DRAIN, which swallows the next resp_valid with no writeback, then IDLE. A store already accepted is not cancelled. The enqueue in a flush cycle is ignored.
- rdy=0: no state change; req_valid remains asserted if set. The cache may not complete a handshake during rdy=0.

Decomposition:
- Shared package: op encodings LB=0,LH=1,LW=2,LBU=4,LHU=5,SB=8,SH=9,SW=10; FSM state encodings IDLE/REQ/WAIT/DRAIN; size constants; NULL_PTR.
- Sub-module lsq_fifo: parametrised DEPTH-entry FIFO with push/pop/flush/full/empty. Load formatter stays inline.

Test Plan:
- LW base=0x100 off=4, resp_data=0xDEADBEEF -> req_addr=0x104 size=4 we=0; wb_en with wb_data=0xDEADBEEF, rd tag preserved.
- LB addr 0x203, resp_data=0x80FF0000 -> wb_data=0xFFFFFF80. LBU same -> 0x00000080. LH addr 0x202 -> 0xFFFF80FF. LHU -> 0x000080FF.
- Enqueue 4 ops with req_ready=0 -> in_ready=0 after 4th, 5th not accepted. Release req_ready -> in-order issue with SW/SB fields exact, pointers wrap correctly.
- LH at 0x101 -> misalign pulse, no req_valid, no wb_en; following SW to 0x108 issues normally.
- Flush while in WAIT with 2 queued ops -> queue empty, the following resp_valid produces no wb_en, busy=0 after it. Flush in REQ -> req_valid drops next cycle.
- Load rd=0 -> req issued, no wb_en. rst asserted in WAIT, then resp_valid -> all outputs at reset values, no writeback.

Source files
------------

// File: rtl/ex_lsq_pkg.sv
// Shared definitions for the ex_lsq load/store execute unit: op codes, FSM states,
// access sizes and small decode helpers used by the queue head logic.
package ex_lsq_pkg;

  localparam logic [3:0] OP_LB  = 4'd0;
  localparam logic [3:0] OP_LH  = 4'd1;
  localparam logic [3:0] OP_LW  = 4'd2;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd8;
  localparam logic [3:0] OP_SH  = 4'd9;
  localparam logic [3:0] OP_SW  = 4'd10;

  localparam logic [2:0] SIZE_NONE = 3'd0;
  localparam logic [2:0] SIZE_B    = 3'd1;
  localparam logic [2:0] SIZE_H    = 3'd2;
  localparam logic [2:0] SIZE_W    = 3'd4;

  localparam int NULL_PTR = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } lsq_state_e;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: op_legal = 1'b1;
      default: op_legal = 1'b0;
    endcase
  endfunction

  // funct3[1:0] carries the access width for both loads and stores.
  function automatic logic [2:0] op_size(input logic [3:0] op);
    case (op[1:0])
      2'd0:    op_size = SIZE_B;
      2'd1:    op_size = SIZE_H;
      default: op_size = SIZE_W;
    endcase
  endfunction

  function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] addr_lo);
    op_misaligned = ((op[1:0] == 2'd1) && addr_lo[0]) ||
                    ((op[1:0] == 2'd2) && (addr_lo != 2'd0));
  endfunction

endpackage

// File: rtl/ex_lsq_fifo.sv
// DEPTH-entry circular FIFO holding address-resolved memory ops; pointers carry
// an extra wrap bit so full and empty are distinguishable.
module lsq_fifo
  import ex_lsq_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= (AW+1)'(NULL_PTR);
      rd_ptr <= (AW+1)'(NULL_PTR);
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && push && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/ex_lsq.sv
// In-order load/store execute unit: queues ops, issues them one at a time to the
// data cache and formats load data for regfile writeback.
module ex_lsq
  import ex_lsq_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int TAG_W = 5,
  parameter int OP_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [XLEN-1:0]  in_base,
  input  logic [XLEN-1:0]  in_offset,
  input  logic [XLEN-1:0]  in_wdata,
  input  logic [TAG_W-1:0] in_target,
  output logic             req_valid,
  input  logic             req_ready,
  output logic             req_we,
  output logic [XLEN-1:0]  req_addr,
  output logic [2:0]       req_size,
  output logic [XLEN-1:0]  req_wdata,
  input  logic             resp_valid,
  input  logic [XLEN-1:0]  resp_data,
  output logic             wb_en,
  output logic [TAG_W-1:0] wb_target,
  output logic [XLEN-1:0]  wb_data,
  output logic             misalign,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int LANE_W = $clog2(XLEN/8);
  localparam int ENT_W  = OP_W + 2*XLEN + TAG_W;

  lsq_state_e       state;
  logic             fifo_full, fifo_empty;
  logic             push, pop, flush_en;
  logic [ENT_W-1:0] enq_entry, head_entry;
  logic [OP_W-1:0]  head_op;
  logic [XLEN-1:0]  head_addr, head_wdata;
  logic [TAG_W-1:0] head_target;
  logic             head_legal, head_misal, idle_drop;
  logic [OP_W-1:0]  ld_op;
  logic [TAG_W-1:0] ld_target;
  logic [LANE_W-1:0] ld_lane;
  logic [XLEN-1:0]  lane_data, fmt_data;

  assign enq_entry = {in_op, in_base + in_offset, in_wdata, in_target};
  assign {head_op, head_addr, head_wdata, head_target} = head_entry;

  assign head_legal = op_legal(4'(head_op));
  assign head_misal = op_misaligned(4'(head_op), head_addr[1:0]);
  assign idle_drop  = (state == ST_IDLE) && !fifo_empty && (!head_legal || head_misal);

  // Handshakes: in_* transfers on a rising edge with in_valid && in_ready, req_*
  // transfers with req_valid && req_ready; both only count when rdy=1 and flush=0.
  // Once raised, req_valid and its fields hold until the transfer or a flush.
  assign in_ready = !fifo_full;
  assign push     = rdy && !flush && in_valid && !fifo_full;
  assign pop      = rdy && !flush && (idle_drop || ((state == ST_REQ) && req_ready));
  assign flush_en = rdy && flush;

  lsq_fifo #(.W(ENT_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .flush   (flush_en),
    .wr_data (enq_entry),
    .rd_data (head_entry),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // The addressed byte/half is moved down to lane 0, then extended per op.
  always_comb begin
    lane_data = resp_data >> {ld_lane, 3'b000};
    fmt_data  = lane_data;
    case (4'(ld_op))
      OP_LB:   fmt_data = {{(XLEN-8){lane_data[7]}}, lane_data[7:0]};
      OP_LBU:  fmt_data = {{(XLEN-8){1'b0}}, lane_data[7:0]};
      OP_LH:   fmt_data = {{(XLEN-16){lane_data[15]}}, lane_data[15:0]};
      OP_LHU:  fmt_data = {{(XLEN-16){1'b0}}, lane_data[15:0]};
      default: fmt_data = lane_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      req_valid <= 1'b0;
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_size  <= SIZE_NONE;
      req_wdata <= '0;
      wb_en     <= 1'b0;
      wb_target <= '0;
      wb_data   <= '0;
      misalign  <= 1'b0;
      ld_op     <= '0;
      ld_target <= '0;
      ld_lane   <= '0;
    end else if (rdy) begin
      wb_en    <= 1'b0;
      misalign <= 1'b0;
      if (flush) begin
        req_valid <= 1'b0;
        // An outstanding load response still has to be absorbed after a flush.
        case (state)
          ST_WAIT, ST_DRAIN: state <= resp_valid ? ST_IDLE : ST_DRAIN;
          default:           state <= ST_IDLE;
        endcase
      end else begin
        case (state)
          ST_IDLE: begin
            if (!fifo_empty && head_legal) begin
              if (head_misal) begin
                misalign <= 1'b1;
              end else begin
                state     <= ST_REQ;
                req_valid <= 1'b1;
                req_we    <= head_op[OP_W-1];
                req_addr  <= head_addr;
                req_size  <= op_size(4'(head_op));
                req_wdata <= head_wdata;
                ld_op     <= head_op;
                ld_target <= head_target;
                ld_lane   <= head_addr[LANE_W-1:0];
              end
            end
          end
          ST_REQ: begin
            if (req_ready) begin
              req_valid <= 1'b0;
              state     <= req_we ? ST_IDLE : ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (resp_valid) begin
              wb_data   <= fmt_data;
              wb_target <= ld_target;
              wb_en     <= (ld_target != '0);
              state     <= ST_IDLE;
            end
          end
          ST_DRAIN: begin
            if (resp_valid) state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy      = !fifo_empty || (state != ST_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_ex_lsq.sv
// Self-checking bench for ex_lsq: a single stimulus process advances time through
// tick(), which samples the DUT on each falling edge against scoreboard queues.
module tb_ex_lsq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_op = '0;
  logic [31:0] in_base = '0, in_offset = '0, in_wdata = '0;
  logic [4:0]  in_target = '0;
  logic        req_valid, req_we;
  logic        req_ready = 1'b1;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_size;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_data = '0;
  logic        wb_en, misalign, busy;
  logic [4:0]  wb_target;
  logic [31:0] wb_data;
  logic [1:0]  dbg_state;

  // clock / reset
  always #5 clk = ~clk;

  ex_lsq dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_base(in_base),
    .in_offset(in_offset), .in_wdata(in_wdata), .in_target(in_target),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_size(req_size), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .wb_en(wb_en), .wb_target(wb_target), .wb_data(wb_data),
    .misalign(misalign), .busy(busy), .dbg_state(dbg_state)
  );

  // scoreboard state
  logic [67:0] req_exp_q[$];   // {we, addr, size, wdata(stores only)}
  logic [36:0] wb_exp_q[$];    // {target, data}
  logic [40:0] pend_load[$];   // {op, addr, target} queued, not yet accepted
  logic [40:0] acc_load[$];    // accepted by the cache, awaiting response
  int n_vec = 0, n_miss = 0;
  int n_load_acc = 0, n_resp = 0;
  int mis_seen = 0, mis_exp = 0;
  logic [3:0] op_tab [8] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10};

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit m_legal(input logic [3:0] op);
    return (op inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10});
  endfunction

  function automatic bit m_misal(input logic [3:0] op, input logic [31:0] a);
    if (op[1:0] == 2'd1) return a[0];
    if (op[1:0] == 2'd2) return a[1:0] != 2'd0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_fmt(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[a[1:0]*8 +: 8];
    h = a[1] ? d[31:16] : d[15:0];
    case (op)
      4'd0:    return {{24{b[7]}}, b};
      4'd4:    return {24'h0, b};
      4'd1:    return {{16{h[15]}}, h};
      4'd5:    return {16'h0, h};
      default: return d;
    endcase
  endfunction

  task automatic monitor();
    logic [67:0] got;
    if (rst) return;
    if (rdy && !flush && req_valid && req_ready) begin
      got = {req_we, req_addr, req_size, req_we ? req_wdata : 32'h0};
      check_val("req_expected", req_exp_q.size() != 0, 1'b1);
      if (req_exp_q.size() != 0) check_val("req_fields", got, req_exp_q.pop_front());
      if (!req_we) begin
        n_load_acc++;
        if (pend_load.size() != 0) acc_load.push_back(pend_load.pop_front());
      end
    end
    if (rdy && wb_en) begin
      check_val("wb_expected", wb_exp_q.size() != 0, 1'b1);
      if (wb_exp_q.size() != 0) check_val("wb_fields", {wb_target, wb_data}, wb_exp_q.pop_front());
    end
    if (rdy && misalign) mis_seen++;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
    end
  endtask

  // driver tasks
  task automatic enq(input logic [3:0] op, input logic [31:0] base, input logic [31:0] off,
                     input logic [31:0] wd, input logic [4:0] tgt);
    int guard = 0;
    logic [31:0] a;
    in_valid = 1'b1; in_op = op; in_base = base; in_offset = off; in_wdata = wd; in_target = tgt;
    while (!in_ready && guard < 100) begin tick(1); guard++; end
    if (guard >= 100) check_val("enq_timeout", in_ready, 1'b1);
    tick(1);
    in_valid = 1'b0; in_op = 4'($urandom); in_base = $urandom; in_wdata = $urandom;
    if (guard >= 100) return;
    a = base + off;
    if (!m_legal(op)) return;
    if (m_misal(op, a)) begin mis_exp++; return; end
    req_exp_q.push_back({op[3], a, (op[1:0] == 2'd0) ? 3'd1 : (op[1:0] == 2'd1) ? 3'd2 : 3'd4,
                         op[3] ? wd : 32'h0});
    if (!op[3]) pend_load.push_back({op, a, tgt});
  endtask

  task automatic wait_load_acc();
    int guard = 0;
    while (n_load_acc <= n_resp && guard < 100) begin tick(1); guard++; end
    if (guard >= 100) check_val("load_accept_timeout", n_load_acc > n_resp, 1'b1);
  endtask

  task automatic respond(input logic [31:0] data, input int lat, input bit drain);
    logic [40:0] ld;
    bit want;
    wait_load_acc();
    if (n_load_acc <= n_resp || acc_load.size() == 0) return;
    ld = acc_load.pop_front();
    n_resp++;
    tick(lat);
    want = !drain && (ld[4:0] != 5'd0);
    if (want) wb_exp_q.push_back({ld[4:0], m_fmt(ld[40:37], ld[36:5], data)});
    resp_valid = 1'b1; resp_data = data;
    tick(1);
    resp_valid = 1'b0; resp_data = $urandom;
    check_val("wb_strobe", wb_en, want);
  endtask

  initial begin
    tick(3);
    rst = 1'b0;
    check_val("rst_in_ready", in_ready, 1'b1);
    check_val("rst_req", {req_valid, req_we, req_addr, req_size, req_wdata}, '0);
    check_val("rst_wb", {wb_en, wb_target, wb_data}, '0);
    check_val("rst_misalign_busy", {misalign, busy}, 2'b00);
    check_val("rst_state", dbg_state, 2'd0);

    // LW with latency checks
    enq(4'd2, 32'h100, 32'h4, 32'h0, 5'd5);
    check_val("lat_req_early", req_valid, 1'b0);
    tick(1);
    check_val("lat_req", req_valid, 1'b1);
    respond(32'hDEADBEEF, 2, 1'b0);

    // byte/half formatting
    enq(4'd0, 32'h200, 32'h3, 32'h0, 5'd6);  respond(32'h80FF0000, 0, 1'b0);
    enq(4'd4, 32'h200, 32'h3, 32'h0, 5'd7);  respond(32'h80FF0000, 1, 1'b0);
    enq(4'd1, 32'h1FE, 32'h4, 32'h0, 5'd8);  respond(32'h80FF0000, 0, 1'b0);
    enq(4'd5, 32'h202, 32'h0, 32'h0, 5'd9);  respond(32'h80FF0000, 3, 1'b0);

    // fill with the cache stalled, fifth op refused
    req_ready = 1'b0;
    enq(4'd10, 32'h1000, 32'h0, 32'h11111111, 5'd0);
    enq(4'd8,  32'h1000, 32'h5, 32'h222222AB, 5'd0);
    enq(4'd10, 32'h1000, 32'hFFFFFFFC, 32'h33333333, 5'd0);
    enq(4'd9,  32'h1000, 32'h2, 32'h4444CDEF, 5'd0);
    check_val("full_in_ready", in_ready, 1'b0);
    in_valid = 1'b1; in_op = 4'd10; in_base = 32'h2000;
    tick(3);
    check_val("full_hold", in_ready, 1'b0);
    in_valid = 1'b0;
    req_ready = 1'b1;
    tick(12);
    check_val("fill_drained", req_exp_q.size(), 0);
    check_val("fill_idle", busy, 1'b0);

    // misaligned half, undefined op, then a normal store
    enq(4'd1, 32'h100, 32'h1, 32'h0, 5'd3);
    enq(4'd3, 32'h100, 32'h0, 32'h0, 5'd3);
    enq(4'd10, 32'h100, 32'h8, 32'hA5A5A5A5, 5'd0);
    tick(8);
    check_val("misalign_count", mis_seen, mis_exp);
    check_val("misalign_drained", req_exp_q.size(), 0);

    // load to x0
    enq(4'd2, 32'h340, 32'h0, 32'h0, 5'd0);
    respond(32'h12345678, 1, 1'b0);

    // flush while waiting with two ops queued; the flush-cycle enqueue is ignored
    enq(4'd2, 32'h400, 32'h0, 32'h0, 5'd3);
    wait_load_acc();
    enq(4'd10, 32'h500, 32'h8, 32'h11223344, 5'd0);
    enq(4'd1, 32'h600, 32'h2, 32'h0, 5'd4);
    flush = 1'b1; in_valid = 1'b1; in_op = 4'd10; in_base = 32'h700; in_offset = 32'h0;
    tick(1);
    flush = 1'b0; in_valid = 1'b0;
    req_exp_q.delete(); pend_load.delete();
    check_val("flush_wait_req", req_valid, 1'b0);
    check_val("flush_wait_busy", busy, 1'b1);
    respond(32'hCAFEF00D, 1, 1'b1);
    tick(3);
    check_val("flush_wait_idle", busy, 1'b0);

    // flush while a request is pending
    req_ready = 1'b0;
    enq(4'd10, 32'h800, 32'h0, 32'h55555555, 5'd0);
    tick(1);
    check_val("flush_req_up", req_valid, 1'b1);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    req_exp_q.delete();
    check_val("flush_req_drop", req_valid, 1'b0);
    req_ready = 1'b1;
    tick(4);
    check_val("flush_req_idle", busy, 1'b0);

    // rdy=0 freezes a pending request
    req_ready = 1'b0;
    enq(4'd9, 32'h900, 32'h6, 32'h0000BEEF, 5'd0);
    tick(1);
    rdy = 1'b0;
    tick(3);
    check_val("rdy_hold", {req_valid, req_addr, req_size}, {1'b1, 32'h906, 3'd2});
    rdy = 1'b1; req_ready = 1'b1;
    tick(3);
    check_val("rdy_drained", req_exp_q.size(), 0);

    // reset abandons an in-flight load; late response ignored
    enq(4'd2, 32'h300, 32'h0, 32'h0, 5'd7);
    wait_load_acc();
    rst = 1'b1;
    tick(1);
    check_val("rst_mid_req", {req_valid, req_we, req_addr, req_size, req_wdata}, '0);
    check_val("rst_mid_wb", {wb_en, wb_target, wb_data, misalign, busy}, '0);
    rst = 1'b0;
    acc_load.delete(); pend_load.delete(); req_exp_q.delete();
    n_resp = n_load_acc;
    resp_valid = 1'b1; resp_data = 32'h77777777;
    tick(1);
    resp_valid = 1'b0;
    tick(2);
    check_val("rst_late_resp", {wb_en, busy}, 2'b00);

    // random mix of loads and stores
    for (int i = 0; i < 24; i++) begin
      logic [3:0]  op;
      logic [31:0] base, off;
      logic [4:0]  tgt;
      op   = op_tab[$urandom_range(0, 7)];
      base = $urandom & 32'hFFFF_FFF0;
      off  = 32'($urandom_range(0, 15));
      tgt  = 5'($urandom_range(0, 31));
      enq(op, base, off, $urandom, tgt);
      if (!op[3] && !m_misal(op, base + off)) respond($urandom, $urandom_range(0, 3), 1'b0);
    end
    tick(10);

    check_val("end_req_q", req_exp_q.size(), 0);
    check_val("end_wb_q", wb_exp_q.size(), 0);
    check_val("end_misalign", mis_seen, mis_exp);
    check_val("end_busy", busy, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
